mem_port_arbiter: RTL and testbench
===================================

# mem_port_arbiter

Shares the single synchronous memory port between the stack-machine core and a host/loader requester. Each requester issues one-word read/write commands with a req/gnt handshake. The arbiter grants at most one command per cycle, round-robin by default, with a host lock mode for program loading. Read data returns with a fixed 1-cycle latency and is routed back to the requester that issued the command.

## Interface
Parameters:
- ADDR_W, 8, address width
- DATA_W, 8, data width
- HOST_FIRST, 0, requester with priority after reset (0 = core, 1 = host)

Ports:
- clock  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- core_req  in  1  core command valid
- core_we  in  1  core write (1) / read (0)
- core_addr  in  ADDR_W  core address
- core_wdata  in  DATA_W  core write data
- core_gnt  out  1  core command accepted this cycle
- core_rvalid  out  1  core read data valid
- core_rdata  out  DATA_W  core read data
- host_req, host_we, host_addr, host_wdata  in  1/1/ADDR_W/DATA_W  host command, same meaning as core
- host_lock  in  1  keep the port granted to the host while asserted
- host_gnt, host_rvalid  out  1  as core
- host_rdata  out  DATA_W  as core
- mem_en  out  1  memory access this cycle
- mem_we  out  1  memory write
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_rdata  in  DATA_W  memory read data, valid the cycle after a read with mem_en=1

## Operation
- States:
  - PRIO_CORE: core wins a tie.
  - PRIO_HOST: host wins a tie.
  - LOCKED: only the host may be granted.
- Reset state is PRIO_CORE, or PRIO_HOST when HOST_FIRST=1.
- Arbitration:
  - Exactly one requester asserting req is granted.
  - When both assert req, the priority holder is granted, and the state moves to give the loser priority.
  - With no request, the state is unchanged.
- Lock:
  - A host grant with host_lock=1 moves the state to LOCKED.
  - In LOCKED, core_req is never granted. host_req is granted every cycle it is asserted.
  - host_lock=0 in LOCKED moves the state to PRIO_CORE in the next cycle. The host may still be granted in that same cycle.
- Grant cycle:
  - gnt is combinational from req and state.
  - mem_en=gnt_any. mem_we, mem_addr and mem_wdata are muxed from the granted requester.
  - The memory outputs are 0 when nothing is granted.
- A requester holds req and its command fields stable until gnt. Back-to-back commands are permitted with no bubble.
- Read return:
  - A registered tag (owner plus was_read) is captured at the grant.
  - The next cycle, the owner's rvalid=1 and its rdata=mem_rdata.
  - The other requester's rdata is 0.
  - Writes produce no rvalid.
- Core and host are never both granted in the same cycle. rvalid is never asserted to both in the same cycle.

## Timing
- Grant latency is 0 cycles from req to gnt when the port is free. Read latency is gnt+1 cycle to rvalid.
- Worst-case core wait with no lock is 1 cycle, because round-robin alternates.
- Reset values:
  - all gnt/rvalid = 0, all rdata = 0
  - mem_en/mem_we = 0, mem_addr/mem_wdata = 0
  - tag cleared, state per HOST_FIRST
- Reset asserted mid-read clears the tag. No rvalid is issued after reset for a read granted before it.
- host_lock asserted while host_req=0 does not lock. LOCKED is entered only on a host grant.
- A read grant in the last cycle before lock release still returns rvalid to the host.

## Structure
- The shared package stack_pkg holds:
  - typedef enum arb_state_e {PRIO_CORE, PRIO_HOST, LOCKED}
  - typedef enum requester_e {REQ_CORE, REQ_HOST}
  - struct mem_cmd_t {we, addr, wdata}
- Sub-module: arb_rr2, a combinational two-way pick. Inputs are req[1:0], prio and lock; outputs are gnt[1:0].
- The top module holds the state register, the tag register and the muxes.

## Test plan
- Core-only read at addr 0x10, memory holding 0x5A:
  - core_gnt=1 in the same cycle, mem_en=1, mem_we=0, mem_addr=0x10.
  - Next cycle core_rvalid=1, core_rdata=0x5A, host_rvalid=0.
- Both requesting continuously from reset: grants alternate core, host, core, host. mem_addr alternates between the two requesters' addresses.
- Host write to 0x03 of 0x77 with host_lock=1 for 4 cycles while core_req=1:
  - core_gnt stays 0 for all 4 cycles.
  - After host_lock drops, core is granted within 1 cycle.
- Back-to-back core reads of 0x01 then 0x02:
  - Two consecutive grants.
  - rvalid on two consecutive cycles with the matching data.
- Reset asserted the cycle after a host read grant: host_rvalid stays 0 and all outputs are 0 while reset is high.
- HOST_FIRST=1 with a simultaneous first request: host is granted first, and core is granted next.

Source files
------------

// File: rtl/stack_pkg.sv
// Shared types for the stack-machine memory port:
// arbiter states, requester ids, command and read-tag bundles.
package stack_pkg;

  localparam int CMD_ADDR_W = 8;
  localparam int CMD_DATA_W = 8;

  typedef enum logic [1:0] {
    PRIO_CORE = 2'd0,
    PRIO_HOST = 2'd1,
    LOCKED    = 2'd2
  } arb_state_e;

  typedef enum logic {
    REQ_CORE = 1'b0,
    REQ_HOST = 1'b1
  } requester_e;

  typedef struct packed {
    logic                  we;
    logic [CMD_ADDR_W-1:0] addr;
    logic [CMD_DATA_W-1:0] wdata;
  } mem_cmd_t;

  // Read-return tag: who owns the next-cycle rdata, if anyone
  typedef struct packed {
    logic       rd;
    requester_e owner;
  } rd_tag_t;

  function automatic arb_state_e rr_flip(
    input arb_state_e s
  );
    return (s == PRIO_CORE) ? PRIO_HOST : PRIO_CORE;
  endfunction

endpackage

// File: rtl/arb_rr2.sv
// Two-way combinational pick: bit 0 is core, bit 1 is host.
// prio selects the tie winner; lock restricts grants to the host.
module arb_rr2
  import stack_pkg::*;
(
  input  logic [1:0] req,
  input  logic       prio,
  input  logic       lock,
  output logic [1:0] gnt
);

  always_comb begin
    gnt = 2'b00;
    unique case (1'b1)
      lock:
        gnt[1] = req[1];
      (!lock && (&req)):
        gnt = prio ? 2'b10 : 2'b01;
      default:
        gnt = req;
    endcase
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one synchronous memory port between core and host,
// round-robin with a host lock, routing 1-cycle read data back.
module mem_port_arbiter
  import stack_pkg::*;
#(
  parameter int ADDR_W     = CMD_ADDR_W,
  parameter int DATA_W     = CMD_DATA_W,
  parameter int HOST_FIRST = 0
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              core_req,
  input  logic              core_we,
  input  logic [ADDR_W-1:0] core_addr,
  input  logic [DATA_W-1:0] core_wdata,
  output logic              core_gnt,
  output logic              core_rvalid,
  output logic [DATA_W-1:0] core_rdata,
  input  logic              host_req,
  input  logic              host_we,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [DATA_W-1:0] host_wdata,
  input  logic              host_lock,
  output logic              host_gnt,
  output logic              host_rvalid,
  output logic [DATA_W-1:0] host_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam arb_state_e RST_STATE =
    (HOST_FIRST != 0) ? PRIO_HOST : PRIO_CORE;

  arb_state_e state_q, state_d;
  rd_tag_t    tag_q, tag_d;

  logic [1:0] req;
  logic [1:0] gnt;
  logic       gnt_any;
  mem_cmd_t   core_cmd, host_cmd, cmd;

  // Requests are masked during reset so all outputs read 0
  assign req = {host_req, core_req} & {2{~reset}};

  arb_rr2 u_pick (
    .req  (req),
    .prio (state_q == PRIO_HOST),
    .lock (state_q == LOCKED),
    .gnt  (gnt)
  );

  assign core_gnt = gnt[0];
  assign host_gnt = gnt[1];
  assign gnt_any  = |gnt;

  assign core_cmd = '{
    we:    core_we,
    addr:  core_addr,
    wdata: core_wdata
  };
  assign host_cmd = '{
    we:    host_we,
    addr:  host_addr,
    wdata: host_wdata
  };

  always_comb begin
    cmd = '0;
    unique case (1'b1)
      gnt[1]:  cmd = host_cmd;
      gnt[0]:  cmd = core_cmd;
      default: cmd = '0;
    endcase
  end

  assign mem_en    = gnt_any;
  assign mem_we    = cmd.we;
  assign mem_addr  = cmd.addr;
  assign mem_wdata = cmd.wdata;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      LOCKED:
        state_d = host_lock ? LOCKED : PRIO_CORE;
      default: begin
        if (gnt[1] && host_lock)
          state_d = LOCKED;
        else if (&req)
          state_d = rr_flip(state_q);
      end
    endcase
  end

  always_comb begin
    tag_d       = '0;
    tag_d.rd    = gnt_any & ~cmd.we;
    tag_d.owner = gnt[1] ? REQ_HOST : REQ_CORE;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= RST_STATE;
      tag_q   <= '0;
    end else begin
      state_q <= state_d;
      tag_q   <= tag_d;
    end
  end

  assign core_rvalid = tag_q.rd && (tag_q.owner == REQ_CORE);
  assign host_rvalid = tag_q.rd && (tag_q.owner == REQ_HOST);
  assign core_rdata  = core_rvalid ? mem_rdata : '0;
  assign host_rdata  = host_rvalid ? mem_rdata : '0;

  always_comb begin
    assert (!(core_gnt && host_gnt));
    assert (!(core_rvalid && host_rvalid));
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a synchronous memory
// model; a second instance covers HOST_FIRST=1.
module tb_mem_port_arbiter;

  logic       clock = 1'b0;
  logic       reset;
  logic       core_req, core_we;
  logic [7:0] core_addr, core_wdata;
  logic       host_req, host_we, host_lock;
  logic [7:0] host_addr, host_wdata;
  logic [7:0] mem_rdata;

  logic       core_gnt, core_rvalid, host_gnt, host_rvalid;
  logic [7:0] core_rdata, host_rdata;
  logic       mem_en, mem_we;
  logic [7:0] mem_addr, mem_wdata;

  logic       h1_core_gnt, h1_core_rvalid;
  logic       h1_host_gnt, h1_host_rvalid;
  logic [7:0] h1_core_rdata, h1_host_rdata;
  logic       h1_mem_en, h1_mem_we;
  logic [7:0] h1_mem_addr, h1_mem_wdata;

  logic [7:0] mem [256];

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clock = ~clock;

  mem_port_arbiter #(
    .ADDR_W(8), .DATA_W(8), .HOST_FIRST(0)
  ) dut (
    .clock(clock), .reset(reset),
    .core_req(core_req), .core_we(core_we),
    .core_addr(core_addr), .core_wdata(core_wdata),
    .core_gnt(core_gnt), .core_rvalid(core_rvalid),
    .core_rdata(core_rdata),
    .host_req(host_req), .host_we(host_we),
    .host_addr(host_addr), .host_wdata(host_wdata),
    .host_lock(host_lock),
    .host_gnt(host_gnt), .host_rvalid(host_rvalid),
    .host_rdata(host_rdata),
    .mem_en(mem_en), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  mem_port_arbiter #(
    .ADDR_W(8), .DATA_W(8), .HOST_FIRST(1)
  ) dut_hf (
    .clock(clock), .reset(reset),
    .core_req(core_req), .core_we(core_we),
    .core_addr(core_addr), .core_wdata(core_wdata),
    .core_gnt(h1_core_gnt), .core_rvalid(h1_core_rvalid),
    .core_rdata(h1_core_rdata),
    .host_req(host_req), .host_we(host_we),
    .host_addr(host_addr), .host_wdata(host_wdata),
    .host_lock(host_lock),
    .host_gnt(h1_host_gnt), .host_rvalid(h1_host_rvalid),
    .host_rdata(h1_host_rdata),
    .mem_en(h1_mem_en), .mem_we(h1_mem_we),
    .mem_addr(h1_mem_addr), .mem_wdata(h1_mem_wdata),
    .mem_rdata(mem_rdata)
  );

  always @(posedge clock) begin
    if (mem_en) begin
      if (mem_we) mem[mem_addr] <= mem_wdata;
      else        mem_rdata <= mem[mem_addr];
    end
  end

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic idle();
    core_req = 0; core_we = 0;
    core_addr = 0; core_wdata = 0;
    host_req = 0; host_we = 0; host_lock = 0;
    host_addr = 0; host_wdata = 0;
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    idle();
    reset = 1;
    tick();
    reset = 0;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    mem[8'h01] = 8'h11;
    mem[8'h02] = 8'h22;
    mem[8'h10] = 8'h5A;
    mem[8'h20] = 8'hA2;
    mem[8'h30] = 8'hB3;
    mem_rdata = 8'h00;
    idle();
    reset = 1;
    repeat (2) @(posedge clock);
    #1;

    // outputs stay quiet in reset even with requests up
    core_req = 1; host_req = 1;
    core_addr = 8'h44; host_addr = 8'h55;
    #2;
    chk("rst_core_gnt", 32'(core_gnt), 0);
    chk("rst_host_gnt", 32'(host_gnt), 0);
    chk("rst_mem_en", 32'(mem_en), 0);
    chk("rst_mem_addr", 32'(mem_addr), 0);
    chk("rst_rvalid", 32'({core_rvalid, host_rvalid}), 0);
    idle();
    reset = 0;
    tick();

    // core-only read of 0x10
    core_req = 1; core_addr = 8'h10;
    #2;
    chk("rd_core_gnt", 32'(core_gnt), 1);
    chk("rd_mem_en", 32'(mem_en), 1);
    chk("rd_mem_we", 32'(mem_we), 0);
    chk("rd_mem_addr", 32'(mem_addr), 'h10);
    tick();
    core_req = 0;
    chk("rd_core_rvalid", 32'(core_rvalid), 1);
    chk("rd_core_rdata", 32'(core_rdata), 'h5A);
    chk("rd_host_rvalid", 32'(host_rvalid), 0);
    chk("rd_host_rdata", 32'(host_rdata), 0);
    #2;
    chk("rd_idle_mem_en", 32'(mem_en), 0);

    // both requesting: alternation, and HOST_FIRST instance
    do_reset();
    core_req = 1; core_addr = 8'h20;
    host_req = 1; host_addr = 8'h30;
    for (int i = 0; i < 4; i++) begin
      #2;
      chk("rr_core_gnt", 32'(core_gnt), (i % 2 == 0) ? 1 : 0);
      chk("rr_host_gnt", 32'(host_gnt), (i % 2 == 1) ? 1 : 0);
      chk("rr_mem_addr", 32'(mem_addr),
          (i % 2 == 0) ? 'h20 : 'h30);
      chk("hf_host_gnt", 32'(h1_host_gnt), (i % 2 == 0) ? 1 : 0);
      chk("hf_core_gnt", 32'(h1_core_gnt), (i % 2 == 1) ? 1 : 0);
      tick();
      chk("rr_core_rvalid", 32'(core_rvalid),
          (i % 2 == 0) ? 1 : 0);
      chk("rr_host_rvalid", 32'(host_rvalid),
          (i % 2 == 1) ? 1 : 0);
      chk("rr_rdata", 32'(core_rdata | host_rdata),
          (i % 2 == 0) ? 'hA2 : 'hB3);
    end

    // host_lock without a host request does not lock
    do_reset();
    host_lock = 1; core_req = 1; core_addr = 8'h10;
    #2;
    chk("nolock_gnt0", 32'(core_gnt), 1);
    tick();
    #2;
    chk("nolock_gnt1", 32'(core_gnt), 1);

    // lock: core wins once, then host holds the port
    do_reset();
    core_req = 1; core_addr = 8'h10;
    host_req = 1; host_we = 1;
    host_addr = 8'h03; host_wdata = 8'h77;
    host_lock = 1;
    #2;
    chk("lk_pre_core_gnt", 32'(core_gnt), 1);
    tick();
    chk("lk_pre_rdata", 32'(core_rdata), 'h5A);
    core_addr = 8'h03;
    for (int i = 0; i < 4; i++) begin
      #2;
      chk("lk_core_gnt", 32'(core_gnt), 0);
      chk("lk_host_gnt", 32'(host_gnt), 1);
      chk("lk_mem_we", 32'(mem_we), 1);
      chk("lk_mem_wdata", 32'(mem_wdata), 'h77);
      tick();
      chk("lk_no_rvalid", 32'({core_rvalid, host_rvalid}), 0);
    end
    host_req = 0; host_lock = 0; host_we = 0;
    #2;
    chk("lk_release_core_gnt", 32'(core_gnt), 0);
    tick();
    #2;
    chk("lk_after_core_gnt", 32'(core_gnt), 1);
    chk("lk_after_mem_addr", 32'(mem_addr), 'h03);
    tick();
    core_req = 0;
    chk("lk_rd_rvalid", 32'(core_rvalid), 1);
    chk("lk_rd_rdata", 32'(core_rdata), 'h77);

    // back-to-back core reads
    do_reset();
    core_req = 1; core_addr = 8'h01;
    #2;
    chk("b2b_gnt0", 32'(core_gnt), 1);
    tick();
    core_addr = 8'h02;
    chk("b2b_rv0", 32'(core_rvalid), 1);
    chk("b2b_rd0", 32'(core_rdata), 'h11);
    #2;
    chk("b2b_gnt1", 32'(core_gnt), 1);
    chk("b2b_addr1", 32'(mem_addr), 'h02);
    tick();
    core_req = 0;
    chk("b2b_rv1", 32'(core_rvalid), 1);
    chk("b2b_rd1", 32'(core_rdata), 'h22);
    tick();
    chk("b2b_rv_end", 32'(core_rvalid), 0);

    // reset lands the cycle after a host read grant
    do_reset();
    host_req = 1; host_addr = 8'h10;
    #2;
    chk("mr_host_gnt", 32'(host_gnt), 1);
    tick();
    reset = 1; core_req = 1; core_addr = 8'h20;
    #2;
    chk("mr_host_rvalid", 32'(host_rvalid), 0);
    chk("mr_host_rdata", 32'(host_rdata), 0);
    chk("mr_gnt", 32'({core_gnt, host_gnt}), 0);
    chk("mr_mem_en", 32'(mem_en), 0);
    chk("mr_mem_addr", 32'(mem_addr), 0);
    idle();
    tick();
    reset = 0;
    #2;
    chk("mr_post_rvalid", 32'(host_rvalid), 0);
    tick();
    chk("mr_post_rvalid2", 32'(host_rvalid), 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
